count_capture: RTL and testbench

//   Initiator/reader side of the counter handshake. Drives the counter's start strobe and

---
 rtl/count_capture_pkg.sv | 21 ++
 rtl/count_capture_edge_sync.sv | 28 ++
 rtl/count_capture.sv | 151 +++++++++++++++
 tb/tb_count_capture.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/count_capture_pkg.sv
// Shared definitions for the capture controller, its counter and the top level:
// FSM state encoding and the default counter geometry.
package count_capture_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQUEST  = 3'd1,
        WAIT_RUN = 3'd2,
        RUN      = 3'd3,
        HOLD     = 3'd4
    } state_t;

    localparam int DEF_WIDTH    = 13;
    localparam int DEF_MAXCOUNT = (1 << DEF_WIDTH) - 1;

    // Counter is driven (enable high) while a measurement is in flight.
    function automatic logic is_active(input state_t s);
        return (s == REQUEST) || (s == WAIT_RUN) || (s == RUN);
    endfunction

endpackage

// File: rtl/count_capture_edge_sync.sv
// Multi-flop synchroniser for an asynchronous level input, followed by a
// registered rising-edge detector producing a single-cycle pulse.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   last;

    // Pulse appears SYNC_STAGES+1 clocks after the pin edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync <= '0;
            last <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            last <= sync[SYNC_STAGES-1];
            rise <= sync[SYNC_STAGES-1] & ~last;
        end
    end

endmodule

// File: rtl/count_capture.sv
// Reader side of the counter handshake: starts the counter on an arm edge and
// latches its count on a stop edge, flagging overflow, false start or start fault.
module count_capture
    import count_capture_pkg::*;
#(
    parameter int               WIDTH         = DEF_WIDTH,
    parameter logic [WIDTH-1:0] MAXCOUNT      = {WIDTH{1'b1}},
    parameter int               START_TIMEOUT = 4,
    parameter int               SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             arm,
    input  logic             stop,
    input  logic             clear,
    input  logic [WIDTH-1:0] count,
    input  logic             done,
    output logic             start_pulse,
    output logic             enable,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             overflow,
    output logic             false_start,
    output logic             fault
);

    localparam int TW = $clog2(START_TIMEOUT + 1);

    state_t        state;
    state_t        state_nxt;
    logic          arm_rise;
    logic          stop_rise;
    logic [TW-1:0] tcnt;
    logic          timeout_hit;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_arm_sync (
        .clk    (clk),
        .resetn (resetn),
        .din    (arm),
        .rise   (arm_rise)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stop_sync (
        .clk    (clk),
        .resetn (resetn),
        .din    (stop),
        .rise   (stop_rise)
    );

    // True during the last permitted WAIT_RUN cycle.
    assign timeout_hit = (tcnt >= TW'(START_TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (arm_rise) state_nxt = REQUEST;
            end
            REQUEST: begin
                state_nxt = WAIT_RUN;
            end
            WAIT_RUN: begin
                if (stop_rise)        state_nxt = HOLD;
                else if (!done)       state_nxt = RUN;
                else if (timeout_hit) state_nxt = HOLD;
            end
            RUN: begin
                if (stop_rise || done) state_nxt = HOLD;
            end
            HOLD: begin
                if (arm_rise)   state_nxt = REQUEST;
                else if (clear) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        start_pulse = (state == REQUEST);
        enable      = is_active(state);
        busy        = is_active(state);
    end

    // Saturating count of WAIT_RUN cycles, restarted by every request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcnt <= '0;
        end else if (state == REQUEST) begin
            tcnt <= '0;
        end else if ((state == WAIT_RUN) && (tcnt != TW'(START_TIMEOUT))) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            false_start  <= 1'b0;
            fault        <= 1'b0;
        end else begin
            case (state)
                WAIT_RUN: begin
                    if (stop_rise) begin
                        result       <= '0;
                        false_start  <= 1'b1;
                        result_valid <= 1'b1;
                    end else if (done && timeout_hit) begin
                        fault        <= 1'b1;
                        result_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop_rise) begin
                        result       <= count;
                        overflow     <= (count == MAXCOUNT);
                        result_valid <= 1'b1;
                    end else if (done) begin
                        result       <= MAXCOUNT;
                        overflow     <= 1'b1;
                        result_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    // Re-arm and clear both drop the flags; result is left as is.
                    if (arm_rise || clear) begin
                        result_valid <= 1'b0;
                        overflow     <= 1'b0;
                        false_start  <= 1'b0;
                        fault        <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_capture.sv
// Randomised bench for count_capture with a behavioural free-running counter and
// a transaction-level expectation of each measurement outcome.
module tb_count_capture;
    import count_capture_pkg::*;

    localparam int WIDTH   = DEF_WIDTH;
    localparam int MAXC    = DEF_MAXCOUNT;
    localparam int SYNC    = 2;
    localparam int TIMEOUT = 4;
    // Count advance between the stop pin edge and the cycle the capture samples.
    localparam int LEAD    = SYNC + 1;

    logic             clk = 1'b0;
    logic             resetn, arm, stop, clear;
    logic [WIDTH-1:0] count = '0;
    logic             done  = 1'b1;
    logic             start_pulse, enable, busy, result_valid;
    logic             overflow, false_start, fault;
    logic [WIDTH-1:0] result;
    logic             stuck_done;

    int checks = 0;
    int errors = 0;
    int sp_count = 0;
    logic sp_prev = 1'b0;
    logic rv_prev = 1'b0;

    always #5 clk = ~clk;

    count_capture #(
        .WIDTH(WIDTH), .START_TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .resetn(resetn), .arm(arm), .stop(stop), .clear(clear),
        .count(count), .done(done), .start_pulse(start_pulse), .enable(enable),
        .busy(busy), .result(result), .result_valid(result_valid),
        .overflow(overflow), .false_start(false_start), .fault(fault)
    );

    // Counter: idles at 0 with done=1, restarts on start, stops at terminal count.
    always @(posedge clk) begin
        if (!enable) begin
            count <= '0;
            done  <= 1'b1;
        end else if (start_pulse && !stuck_done) begin
            count <= '0;
            done  <= 1'b0;
        end else if (!done) begin
            count <= count + 1'b1;
            if (int'(count) == MAXC - 1) done <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (start_pulse) begin
            check("start_pulse_consecutive", sp_prev, 0);
            sp_count++;
        end
        if (result_valid && !rv_prev)
            check("flags_at_most_one", ($countones({overflow, false_start, fault}) <= 1), 1);
        sp_prev = start_pulse;
        rv_prev = result_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int bound, output int busy_n);
        int n;
        n = 0;
        busy_n = 0;
        while (n < bound) begin
            tick(1);
            n++;
            if (result_valid) break;
            if (busy) busy_n++;
        end
        check("wait_valid", result_valid, 1);
    endtask

    task automatic wait_count(input int target);
        int n;
        n = 0;
        while (int'(count) != target && n < 9000) begin
            tick(1);
            n++;
        end
    endtask

    // Arm, stop so that the sampled count equals t, then compare the outcome.
    task automatic run_stop(input string tag, input int t);
        int b, sp0;
        sp0 = sp_count;
        arm = 1'b1; tick(3); arm = 1'b0;
        wait_count(t - LEAD);
        stop = 1'b1;
        wait_valid(20, b);
        stop = 1'b0;
        check({tag, "_result"}, result, t);
        check({tag, "_flags"}, {overflow, false_start, fault}, {1'b0, 1'b0, (t == MAXC)} >> 0 & 3'b000 | ((t == MAXC) ? 3'b100 : 3'b000));
        check({tag, "_enable"}, enable, 0);
        check({tag, "_starts"}, sp_count - sp0, 1);
    endtask

    initial begin
        int b, sp0, t;
        resetn = 1'b0; arm = 1'b0; stop = 1'b0; clear = 1'b0; stuck_done = 1'b0;
        tick(3);
        check("reset_outputs", {start_pulse, enable, busy, result_valid, overflow, false_start, fault}, 0);
        check("reset_result", result, 0);
        resetn = 1'b1;
        tick(2);

        // Normal measurement.
        run_stop("normal", 1000);

        // Overflow without stop, then stop coinciding with terminal count.
        arm = 1'b1; tick(3); arm = 1'b0;
        wait_valid(9000, b);
        check("ovf_result", result, MAXC);
        check("ovf_flags", {overflow, false_start, fault}, 3'b100);
        run_stop("ovf_stop", MAXC);

        // False start: stop pulse lands in the cycle right after start_pulse.
        arm = 1'b1; tick(2); stop = 1'b1; tick(1); arm = 1'b0;
        wait_valid(20, b);
        stop = 1'b0;
        check("fs_flags", {overflow, false_start, fault}, 3'b010);
        check("fs_result", result, 0);
        check("fs_busy_cycles", b, 2);

        // Re-arm from HOLD without clear; arm edges during RUN are ignored.
        sp0 = sp_count;
        arm = 1'b1; tick(3); arm = 1'b0;
        b = 0;
        while (!start_pulse && b < 10) begin tick(1); b++; end
        check("rearm_start", start_pulse, 1);
        check("rearm_cleared", {result_valid, overflow, false_start, fault}, 0);
        wait_count(200);
        arm = 1'b1; tick(3); arm = 1'b0;
        wait_count(600 - LEAD);
        stop = 1'b1;
        wait_valid(20, b);
        stop = 1'b0;
        check("rearm_result", result, 600);
        check("rearm_starts", sp_count - sp0, 1);

        // Start fault: counter never leaves done.
        stuck_done = 1'b1;
        arm = 1'b1; tick(3); arm = 1'b0;
        wait_valid(30, b);
        check("fault_flags", {overflow, false_start, fault}, 3'b001);
        check("fault_wait_cycles", b, TIMEOUT + 1);
        stuck_done = 1'b0;
        clear = 1'b1; tick(1); clear = 1'b0;
        tick(1);
        check("clear_outputs", {result_valid, overflow, false_start, fault, busy, enable}, 0);

        // Asynchronous reset in the middle of a run.
        arm = 1'b1; tick(3); arm = 1'b0;
        wait_count(500);
        @(posedge clk); #2;
        check("pre_reset_busy", busy, 1);
        resetn = 1'b0; #1;
        check("async_reset_outputs", {start_pulse, enable, busy, result_valid, overflow, false_start, fault}, 0);
        check("async_reset_result", result, 0);
        tick(2);
        resetn = 1'b1;
        tick(3);
        check("post_reset_idle", {busy, enable, result_valid}, 0);

        // Randomised measurements, randomly cleared or re-armed.
        for (int i = 0; i < 6; i++) begin
            t = $urandom_range(2500, 4);
            run_stop("rand", t);
            if ($urandom_range(1, 0) == 1) begin
                clear = 1'b1; tick(1); clear = 1'b0; tick(1);
                check("rand_clear", result_valid, 0);
            end
            tick($urandom_range(6, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
